// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared seven-segment codes, display constants and arbiter states
package disp_pkg;

  // Active-low segment codes, bit 7 = dp (unlit), bits 6:0 = g..a
  localparam logic [7:0] SEG_D0    = 8'hC0;
  localparam logic [7:0] SEG_D1    = 8'hF9;
  localparam logic [7:0] SEG_D2    = 8'hA4;
  localparam logic [7:0] SEG_D3    = 8'hB0;
  localparam logic [7:0] SEG_D4    = 8'h99;
  localparam logic [7:0] SEG_D5    = 8'h92;
  localparam logic [7:0] SEG_D6    = 8'h82;
  localparam logic [7:0] SEG_D7    = 8'hF8;
  localparam logic [7:0] SEG_D8    = 8'h80;
  localparam logic [7:0] SEG_D9    = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [5:0] SEL_OFF   = 6'h3F;

  typedef enum logic [1:0] {
    ST_STATUS     = 2'd0,
    ST_ALERT_PEND = 2'd1,
    ST_ALERT      = 2'd2
  } arb_state_t;

  // Leading-zero blank mask: walk down from digit 5, blanking zero digits
  // until a non-zero digit or a lit dp is met. Digit 0 always stays visible.
  function automatic logic [5:0] lz_mask(input logic [23:0] bcd,
                                         input logic [5:0]  dp,
                                         input logic        en);
    logic       lead;
    logic [5:0] mask;
    lead = en;
    mask = '0;
    for (int i = 5; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0) && !dp[i]) mask[i] = 1'b1;
      else                                            lead    = 1'b0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// rtl/bcd7seg.sv - combinational BCD plus decimal point to active-low segment decoder
module bcd7seg
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] w_code;

  // Digit lookup; non-decimal codes render as a dash
  always_comb begin
    case (i_bcd)
      4'd0:    w_code = SEG_D0;
      4'd1:    w_code = SEG_D1;
      4'd2:    w_code = SEG_D2;
      4'd3:    w_code = SEG_D3;
      4'd4:    w_code = SEG_D4;
      4'd5:    w_code = SEG_D5;
      4'd6:    w_code = SEG_D6;
      4'd7:    w_code = SEG_D7;
      4'd8:    w_code = SEG_D8;
      4'd9:    w_code = SEG_D9;
      default: w_code = SEG_DASH;
    endcase
  end

  assign o_seg = {w_code[7] & ~i_dp, w_code[6:0]};

endmodule

// File: rtl/disp_scan_sched.sv
// rtl/disp_scan_sched.sv - 6-digit display scan scheduler with status/alert source arbiter
module disp_scan_sched
  import disp_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 50,
  parameter int HOLD_FRAMES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] status_bcd,
  input  logic [5:0]  status_dp,
  input  logic        status_lz_en,
  input  logic        alert_req,
  input  logic [23:0] alert_bcd,
  input  logic [5:0]  alert_dp,
  output logic        alert_ack,
  output logic        alert_busy,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES);

  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_idx;
  arb_state_t        r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [23:0]       r_abuf_bcd;
  logic [5:0]        r_abuf_dp;
  logic [23:0]       r_snap_bcd;
  logic [5:0]        r_snap_dp;
  logic [5:0]        r_snap_blank;
  logic [5:0]        r_sel;
  logic [7:0]        r_seg;
  logic              r_ack;
  logic              r_busy;
  logic              r_tick;

  logic              w_slot_end;
  logic              w_frame_end;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [2:0]        w_idx_nxt;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              w_expire;
  logic              w_load_status;
  logic              w_load_alert;
  logic [23:0]       w_snap_bcd_nxt;
  logic [5:0]        w_snap_dp_nxt;
  logic [5:0]        w_snap_blank_nxt;
  logic [7:0]        w_dec_seg;
  logic [5:0]        w_sel_on;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 3'd0);
  assign w_cnt_nxt   = w_slot_end ? '0 : r_cnt + CNT_W'(1);
  assign w_idx_nxt   = !w_slot_end ? r_idx : ((r_idx == 3'd0) ? 3'd5 : r_idx - 3'd1);
  assign w_hold_inc  = r_hold + HOLD_W'(1);

  assign w_expire      = (r_state == ST_ALERT) && w_frame_end && (w_hold_inc == HOLD_LAST);
  assign w_load_status = w_frame_end && ((r_state == ST_STATUS) || w_expire);
  assign w_load_alert  = w_frame_end && (r_state == ST_ALERT_PEND);

  // Content for the upcoming cycle: only replaced at a frame boundary, so a frame never tears
  always_comb begin
    w_snap_bcd_nxt   = r_snap_bcd;
    w_snap_dp_nxt    = r_snap_dp;
    w_snap_blank_nxt = r_snap_blank;
    if (w_load_status) begin
      w_snap_bcd_nxt   = status_bcd;
      w_snap_dp_nxt    = status_dp;
      w_snap_blank_nxt = lz_mask(status_bcd, status_dp, status_lz_en);
    end else if (w_load_alert) begin
      w_snap_bcd_nxt   = r_abuf_bcd;
      w_snap_dp_nxt    = r_abuf_dp;
      w_snap_blank_nxt = '0;
    end
  end

  bcd7seg u_dec (
    .i_bcd (w_snap_bcd_nxt[{w_idx_nxt, 2'b00} +: 4]),
    .i_dp  (w_snap_dp_nxt[w_idx_nxt]),
    .o_seg (w_dec_seg)
  );

  assign w_sel_on = ~(6'b000001 << w_idx_nxt);

  // Slot/digit counters and pin drivers, registered from next-cycle values so pins track cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= 3'd5;
      r_sel  <= SEL_OFF;
      r_seg  <= SEG_BLANK;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_idx  <= w_idx_nxt;
      r_tick <= w_frame_end;
      if (w_cnt_nxt < BLANK_END) begin
        r_sel <= SEL_OFF;
        r_seg <= SEG_BLANK;
      end else begin
        r_sel <= w_sel_on;
        r_seg <= w_snap_blank_nxt[w_idx_nxt] ? SEG_BLANK : w_dec_seg;
      end
    end
  end

  // Source arbiter: accept alerts only while showing status, hold them for whole frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_STATUS;
      r_hold       <= '0;
      r_abuf_bcd   <= '0;
      r_abuf_dp    <= '0;
      r_snap_bcd   <= '0;
      r_snap_dp    <= '0;
      r_snap_blank <= 6'h3F;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ack        <= 1'b0;
      r_snap_bcd   <= w_snap_bcd_nxt;
      r_snap_dp    <= w_snap_dp_nxt;
      r_snap_blank <= w_snap_blank_nxt;
      case (r_state)
        ST_STATUS: begin
          if (alert_req) begin
            r_ack      <= 1'b1;
            r_busy     <= 1'b1;
            r_abuf_bcd <= alert_bcd;
            r_abuf_dp  <= alert_dp;
            r_state    <= ST_ALERT_PEND;
          end
        end
        ST_ALERT_PEND: begin
          if (w_frame_end) begin
            r_hold  <= '0;
            r_state <= ST_ALERT;
          end
        end
        ST_ALERT: begin
          if (w_frame_end) begin
            r_hold <= w_hold_inc;
            if (w_expire) begin
              r_busy  <= 1'b0;
              r_state <= ST_STATUS;
            end
          end
        end
        default: r_state <= ST_STATUS;
      endcase
    end
  end

  assign sel        = r_sel;
  assign seg        = r_seg;
  assign alert_ack  = r_ack;
  assign alert_busy = r_busy;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_disp_scan_sched.sv
// tb/tb_disp_scan_sched.sv - randomized self-checking bench for disp_scan_sched
module tb_disp_scan_sched;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int HF = 3;
  localparam int FR = 6 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] status_bcd = '0;
  logic [5:0]  status_dp = '0;
  logic        status_lz_en = 1'b0;
  logic        alert_req = 1'b0;
  logic [23:0] alert_bcd = '0;
  logic [5:0]  alert_dp = '0;
  logic        alert_ack;
  logic        alert_busy;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_tick;

  always #5 clk = ~clk;

  disp_scan_sched #(.SCAN_DIV(SD), .BLANK_CYC(BC), .HOLD_FRAMES(HF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .status_bcd   (status_bcd),
    .status_dp    (status_dp),
    .status_lz_en (status_lz_en),
    .alert_req    (alert_req),
    .alert_bcd    (alert_bcd),
    .alert_dp     (alert_dp),
    .alert_ack    (alert_ack),
    .alert_busy   (alert_busy),
    .sel          (sel),
    .seg          (seg),
    .frame_tick   (frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-cycle time index plus what each frame is expected to show
  logic [7:0] ref_tbl [16];
  logic [7:0] m_frame_seg [6];
  int         m_t;
  logic       m_ack_q, m_tick_q, m_busy, m_wait;
  int         m_hold;
  logic [23:0] m_abuf;
  logic [5:0]  m_adp;

  function automatic logic [7:0] ref_code(input logic [3:0] d, input logic dp);
    return ref_tbl[d] & (dp ? 8'h7F : 8'hFF);
  endfunction

  task automatic load_status();
    int top;
    top = 0;
    if (!status_lz_en) top = 5;
    else for (int i = 0; i < 6; i++)
      if (status_bcd[4*i +: 4] != 4'd0 || status_dp[i]) top = i;
    for (int i = 0; i < 6; i++)
      m_frame_seg[i] = (i > top) ? 8'hFF : ref_code(status_bcd[4*i +: 4], status_dp[i]);
  endtask

  task automatic load_alert();
    for (int i = 0; i < 6; i++) m_frame_seg[i] = ref_code(m_abuf[4*i +: 4], m_adp[i]);
  endtask

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < 6; i++) m_frame_seg[i] = 8'hFF;
    m_ack_q = 1'b0; m_tick_q = 1'b0; m_busy = 1'b0; m_wait = 1'b0; m_hold = 0;
  endtask

  // Advance the model across one clock edge using the inputs the DUT is about to sample
  task automatic model_step();
    logic old_busy;
    logic bnd;
    old_busy = m_busy;
    bnd      = ((m_t + 1) % FR) == 0;
    m_tick_q = bnd;
    if (bnd) begin
      if (m_wait) begin
        load_alert(); m_wait = 1'b0; m_hold = HF;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin load_status(); m_busy = 1'b0; end
      end else begin
        load_status();
      end
    end
    m_ack_q = !old_busy && alert_req;
    if (m_ack_q) begin
      m_abuf = alert_bcd; m_adp = alert_dp; m_busy = 1'b1; m_wait = 1'b1;
    end
    m_t++;
  endtask

  task automatic compare();
    int c, dig;
    logic [5:0] es;
    logic [7:0] eg;
    c   = m_t % SD;
    dig = 5 - (m_t % FR) / SD;
    es  = 6'h3F;
    eg  = 8'hFF;
    if (c >= BC) begin
      es[dig] = 1'b0;
      eg      = m_frame_seg[dig];
    end
    check_eq("sel", 32'(sel), 32'(es));
    check_eq("seg", 32'(seg), 32'(eg));
    check_eq("alert_ack", 32'(alert_ack), 32'(m_ack_q));
    check_eq("alert_busy", 32'(alert_busy), 32'(m_busy));
    check_eq("frame_tick", 32'(frame_tick), 32'(m_tick_q));
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    compare();
    if (alert_ack) begin n_ack++; alert_req = 1'b0; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_reset();
    compare();
  endtask

  initial begin
    int waited;
    ref_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    status_bcd = 24'h001250; status_dp = 6'h00; status_lz_en = 1'b1;
    repeat (3) @(negedge clk);
    release_reset();
    run(3 * FR);

    status_lz_en = 1'b0; status_bcd = 24'h001B50;
    run(2 * FR);
    status_dp = 6'b000001;
    run(2 * FR);
    status_bcd = 24'h034000; status_dp = 6'h00; status_lz_en = 1'b1;
    run(20);

    alert_bcd = 24'h888888; alert_dp = 6'h00; alert_req = 1'b1; n_ack = 0;
    waited = 0;
    while (n_ack == 0 && waited < 20) begin step(); waited++; end
    check_eq("ack_latency", 32'(waited), 32'd1);
    run(FR + 10);
    check_eq("ack_single", 32'(n_ack), 32'd1);

    alert_bcd = 24'h12A456; alert_dp = 6'b010000; alert_req = 1'b1; n_ack = 0;
    waited = 0;
    while (alert_busy && waited < 6 * FR) begin step(); waited++; end
    check_eq("busy_fell", 32'(alert_busy), 32'd0);
    check_eq("no_ack_while_busy", 32'(n_ack), 32'd0);
    run(2);
    check_eq("ack_after_busy", 32'(n_ack), 32'd1);
    run(FR + FR / 2);
    check_eq("collision_one_ack", 32'(n_ack), 32'd1);
    check_eq("second_alert_busy", 32'(alert_busy), 32'd1);

    #3 rst_n = 1'b0; alert_req = 1'b0;
    #1;
    check_eq("rst_sel", 32'(sel), 32'h3F);
    check_eq("rst_seg", 32'(seg), 32'hFF);
    check_eq("rst_busy", 32'(alert_busy), 32'd0);
    check_eq("rst_ack", 32'(alert_ack), 32'd0);
    check_eq("rst_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(negedge clk);
    release_reset();
    run(2 * FR + 5);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 40) == 0) begin
        status_bcd   = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
        status_dp    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
        status_lz_en = 1'($urandom);
      end
      if (!alert_req && $urandom_range(0, 400) == 0) begin
        alert_req = 1'b1;
        alert_bcd = 24'($urandom);
        alert_dp  = 6'($urandom);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
